// File: rtl/tug_of_war_field_if.sv
// Button inputs and playfield/score outputs of the tug-of-war field.
// The slave modport is the field itself; the master modport is the button/display side.
interface tug_of_war_field_if #(
  parameter int NUM_LIGHTS  = 9,
  parameter int SCORE_WIDTH = 3
);
  logic                   L;
  logic                   R;
  logic [NUM_LIGHTS-1:0]  lights;
  logic [1:0]             winner;
  logic [SCORE_WIDTH-1:0] left_score;
  logic [SCORE_WIDTH-1:0] right_score;
  logic                   game_over;

  modport master (
    output L, R,
    input  lights, winner, left_score, right_score, game_over
  );

  modport slave (
    input  L, R,
    output lights, winner, left_score, right_score, game_over
  );
endinterface

// File: rtl/tug_of_war_field.sv
// Tug-of-war playfield: edge-detected presses move a one-hot light, with round/game scoring.
// A press sampled at a clock edge is reflected in the registered outputs at that edge; no backpressure.
module tug_of_war_field #(
  parameter int NUM_LIGHTS  = 9,
  parameter int SCORE_WIDTH = 3
) (
  input  logic              clk,
  input  logic              reset,
  tug_of_war_field_if.slave io
);
  localparam int POS_W = $clog2(NUM_LIGHTS);
  localparam logic [POS_W-1:0] CENTRE   = POS_W'((NUM_LIGHTS - 1) / 2);
  localparam logic [POS_W-1:0] LEFT_END = POS_W'(NUM_LIGHTS - 1);
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {PLAY, ROUND_END, GAME_OVER} state_t;

  state_t                 state, state_nxt;
  logic [POS_W-1:0]       pos, pos_nxt;
  logic [1:0]             winner, winner_nxt;
  logic [SCORE_WIDTH-1:0] left_score, left_score_nxt;
  logic [SCORE_WIDTH-1:0] right_score, right_score_nxt;
  logic [NUM_LIGHTS-1:0]  lights, lights_nxt;
  logic                   game_over, game_over_nxt;
  logic                   l_prev, r_prev;
  logic                   lp, rp;

  assign lp = io.L & ~l_prev;
  assign rp = io.R & ~r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= PLAY;
      pos         <= CENTRE;
      winner      <= 2'b00;
      left_score  <= '0;
      right_score <= '0;
      lights      <= NUM_LIGHTS'(1) << CENTRE;
      game_over   <= 1'b0;
      l_prev      <= 1'b0;
      r_prev      <= 1'b0;
    end else begin
      state       <= state_nxt;
      pos         <= pos_nxt;
      winner      <= winner_nxt;
      left_score  <= left_score_nxt;
      right_score <= right_score_nxt;
      lights      <= lights_nxt;
      game_over   <= game_over_nxt;
      l_prev      <= io.L;
      r_prev      <= io.R;
    end
  end

  always_comb begin
    state_nxt       = state;
    pos_nxt         = pos;
    winner_nxt      = winner;
    left_score_nxt  = left_score;
    right_score_nxt = right_score;
    unique case (state)
      PLAY: begin
        winner_nxt = 2'b00;
        if (lp && !rp) begin
          if (pos == LEFT_END) begin
            winner_nxt     = 2'b01;
            left_score_nxt = left_score + SCORE_WIDTH'(1);
            state_nxt      = (left_score_nxt == SCORE_MAX) ? GAME_OVER : ROUND_END;
          end else begin
            pos_nxt = pos + POS_W'(1);
          end
        end else if (rp && !lp) begin
          if (pos == '0) begin
            winner_nxt      = 2'b10;
            right_score_nxt = right_score + SCORE_WIDTH'(1);
            state_nxt       = (right_score_nxt == SCORE_MAX) ? GAME_OVER : ROUND_END;
          end else begin
            pos_nxt = pos - POS_W'(1);
          end
        end
      end
      ROUND_END: begin
        // The restarting press only recentres; it never moves the light.
        if (lp || rp) begin
          state_nxt  = PLAY;
          pos_nxt    = CENTRE;
          winner_nxt = 2'b00;
        end
      end
      GAME_OVER: ;
      default: state_nxt = PLAY;
    endcase
  end

  always_comb begin
    lights_nxt    = '0;
    game_over_nxt = (state_nxt == GAME_OVER);
    if (state_nxt == PLAY)
      lights_nxt[pos_nxt] = 1'b1;
  end

  assign io.lights      = lights;
  assign io.winner      = winner;
  assign io.left_score  = left_score;
  assign io.right_score = right_score;
  assign io.game_over   = game_over;
endmodule

// File: tb/tb_tug_of_war_field.sv
// Directed bench for tug_of_war_field with NUM_LIGHTS=5, SCORE_WIDTH=2.
module tb_tug_of_war_field;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  tug_of_war_field_if #(.NUM_LIGHTS(5), .SCORE_WIDTH(2)) io ();

  tug_of_war_field #(.NUM_LIGHTS(5), .SCORE_WIDTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are read at the next falling edge.
  task automatic step(input logic l, input logic r);
    io.L = l;
    io.R = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press(input logic l, input logic r);
    step(1'b0, 1'b0);
    step(l, r);
  endtask

  task automatic do_reset();
    io.L  = 1'b0;
    io.R  = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [4:0] li, input logic [1:0] w,
                           input logic [1:0] ls, input logic [1:0] rs, input logic go);
    check({tag, ".lights"}, 32'(io.lights), 32'(li));
    check({tag, ".winner"}, 32'(io.winner), 32'(w));
    check({tag, ".lscore"}, 32'(io.left_score), 32'(ls));
    check({tag, ".rscore"}, 32'(io.right_score), 32'(rs));
    check({tag, ".gover"}, 32'(io.game_over), 32'(go));
  endtask

  initial begin
    io.L = 1'b0;
    io.R = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all("reset", 5'b00100, 2'b00, 2'd0, 2'd0, 1'b0);

    // Held L gives one press only
    step(1'b1, 1'b0);
    check("hold0", 32'(io.lights), 32'(5'b01000));
    for (int i = 1; i < 4; i++) begin
      step(1'b1, 1'b0);
      check("hold", 32'(io.lights), 32'(5'b01000));
    end
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("repress", 32'(io.lights), 32'(5'b10000));

    // Simultaneous presses cancel
    do_reset();
    step(1'b1, 1'b1);
    check("simul", 32'(io.lights), 32'(5'b00100));
    press(1'b0, 1'b1);
    check("r_after_simul", 32'(io.lights), 32'(5'b00010));

    // Full left round, restart, full right round
    do_reset();
    press(1'b1, 1'b0);
    check("l1", 32'(io.lights), 32'(5'b01000));
    press(1'b1, 1'b0);
    check("l2", 32'(io.lights), 32'(5'b10000));
    press(1'b1, 1'b0);
    check_all("lwin", 5'b00000, 2'b01, 2'd1, 2'd0, 1'b0);
    step(1'b0, 1'b0);
    check_all("lwin_hold", 5'b00000, 2'b01, 2'd1, 2'd0, 1'b0);
    press(1'b0, 1'b1);
    check_all("restart", 5'b00100, 2'b00, 2'd1, 2'd0, 1'b0);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    check("r2", 32'(io.lights), 32'(5'b00001));
    press(1'b0, 1'b1);
    check_all("rwin", 5'b00000, 2'b10, 2'd1, 2'd1, 1'b0);

    // Left wins three rounds -> game over
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) press(1'b1, 1'b0);
      check("round_score", 32'(io.left_score), 32'(r + 1));
      if (r < 2) press(1'b1, 1'b0);
    end
    check_all("gameover", 5'b00000, 2'b01, 2'd3, 2'd0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    check_all("go_ignore", 5'b00000, 2'b01, 2'd3, 2'd0, 1'b1);
    do_reset();
    check_all("go_reset", 5'b00100, 2'b00, 2'd0, 2'd0, 1'b0);

    // Asynchronous reset between edges, mid-round with a nonzero score
    for (int k = 0; k < 3; k++) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check_all("pre_async", 5'b10000, 2'b00, 2'd0, 2'd1, 1'b0);
    io.L = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_all("async", 5'b00100, 2'b00, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    press(1'b0, 1'b1);
    check("post_async", 32'(io.lights), 32'(5'b00010));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/tug_of_war_field.md
Name: tug_of_war_field

Overview:
- Parametrised tug-of-war playfield: a row of NUM_LIGHTS lights with exactly one lit during play.
- Left/right player presses push the lit position toward the pressing player's end; pushing off an end wins the round.
- Keeps per-player round scores and ends the game when either score saturates.
- Replaces the per-light centre/normal cell array; sits between the button synchronisers and the LED/HEX drivers.

Parameters:
NUM_LIGHTS, 9, number of lights in the row; odd, >= 3
SCORE_WIDTH, 3, width of each score counter; game ends at score 2**SCORE_WIDTH-1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
L  input  1  left player button, already synchronised, level
R  input  1  right player button, already synchronised, level
lights  output  NUM_LIGHTS  one-hot position; bit NUM_LIGHTS-1 is leftmost
winner  output  2  00 none, 01 left won last round, 10 right won last round
left_score  output  SCORE_WIDTH  left rounds won
right_score  output  SCORE_WIDTH  right rounds won
game_over  output  1  high once either score reaches max

Behaviour:
- Reset is asynchronous; all state and outputs clear immediately on assertion, with no clock required.
- Reset values:
  - lights has only the centre bit set, index (NUM_LIGHTS-1)/2.
  - winner=00, both scores 0, game_over=0, state PLAY.
  - Internal L_prev/R_prev = 0.
- Edge detect:
  - Lp = L & ~L_prev; Rp = R & ~R_prev.
  - L_prev/R_prev are registered every clock in all states.
  - A held button produces exactly one press.
- Latency: a press sampled at clock edge k updates lights, winner and scores at that same edge k; all outputs are registered.
- State PLAY, internal position pos:
  - Lp&~Rp: if pos==NUM_LIGHTS-1, go to ROUND_END with winner=01; else pos=pos+1.
  - Rp&~Lp: if pos==0, go to ROUND_END with winner=10; else pos=pos-1.
  - Lp&Rp (simultaneous) or neither: hold; no move.
  - winner=00 throughout PLAY.
- Entering ROUND_END:
  - lights=0.
  - Winning player's score increments at the same edge.
  - If the new score equals 2**SCORE_WIDTH-1, go to GAME_OVER instead of ROUND_END.
- State ROUND_END:
  - lights=0; winner holds.
  - The first Lp or Rp returns to PLAY with pos=centre and winner=00.
  - That press does not move the light.
- State GAME_OVER:
  - lights=0, winner holds, game_over=1.
  - All presses are ignored until reset.
- Scores:
  - Never wrap; saturation is guaranteed by GAME_OVER.
  - Only reset clears them; there is no per-round clear.
- Invariant: in PLAY, lights is always exactly one-hot.
- Reset mid-round or in any state: returns to reset values, scores included.

Test Plan:
1. NUM_LIGHTS=5, SCORE_WIDTH=2: assert reset, then release -> lights=00100, winner=00, scores 0/0, game_over=0.
2. Hold L high 4 cycles from reset -> lights=01000 after the first edge and stays 01000; L low then high again -> 10000.
3. L and R rise at the same edge from centre -> lights stays 00100; a following R-only press -> 00010.
4. Three L presses from centre -> 01000, 10000, then lights=00000, winner=01, left_score=1. Next R press -> lights=00100, winner=00, no move. Then R twice -> 00001; a third R -> winner=10, right_score=1.
5. Left wins 3 rounds -> game_over=1, left_score=3, lights=0; further L/R presses change nothing. Reset -> lights=00100, scores 0, game_over=0.
6. Assert reset between clock edges mid-round with lights=10000 -> outputs show reset values before the next posedge; pos restarts at centre after release.
